dmem_arbiter_ctrl: RTL and testbench

DMEM_ARBITER_CTRL -- requirements
Module: dmem_arbiter_ctrl

---
 rtl/dmem_arbiter_ctrl.sv | 158 +++++++++++++++
 tb/tb_dmem_arbiter_ctrl.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter_ctrl.sv
// Data-memory arbiter between the MEM-stage load/store path and a debug port.
// Debug waits behind the pipeline until it has starved for STARVE_LIMIT cycles.
module dmem_arbiter_ctrl #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_mem_read,
  input  logic        mem_mem_write,
  input  logic [31:0] mem_alu_result,
  input  logic [31:0] mem_rs2_val_for_store,
  input  logic [1:0]  mem_store_size,
  output logic        pipe_stall,
  output logic [31:0] pipe_rdata,
  output logic        pipe_rvalid,
  output logic        pipe_misalign,
  input  logic        dbg_req,
  input  logic        dbg_we,
  input  logic [31:0] dbg_addr,
  input  logic [31:0] dbg_wdata,
  output logic        dbg_gnt,
  output logic [31:0] dbg_rdata,
  output logic        dbg_rvalid,
  output logic        dm_req,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wdata,
  output logic [3:0]  dm_be,
  input  logic        dm_ready,
  input  logic [31:0] dm_rdata
);

  localparam int CW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    IDLE,
    PIPE_BUSY,
    DBG_BUSY
  } state_t;

  state_t        state;
  logic [CW-1:0] starve_cnt;

  logic        pipe_acc;
  logic        misal;
  logic        aligned_acc;
  logic        starved;
  logic        dbg_win;
  logic        pipe_win;
  logic [3:0]  pipe_be;
  logic [31:0] pipe_wdata;

  // Decode access size into alignment, byte lanes and lane-replicated data
  always_comb begin
    misal      = 1'b0;
    pipe_be    = 4'b1111;
    pipe_wdata = mem_rs2_val_for_store;
    unique case (mem_store_size)
      2'b00: begin
        pipe_be    = 4'b0001 << mem_alu_result[1:0];
        pipe_wdata = {4{mem_rs2_val_for_store[7:0]}};
      end
      2'b01: begin
        misal      = mem_alu_result[0];
        pipe_be    = 4'b0011 << mem_alu_result[1:0];
        pipe_wdata = {2{mem_rs2_val_for_store[15:0]}};
      end
      default: begin
        misal = |mem_alu_result[1:0];
      end
    endcase
  end

  assign pipe_acc    = mem_mem_read | mem_mem_write;
  assign aligned_acc = pipe_acc & ~misal;
  assign starved     = (starve_cnt >= LIMIT);
  assign dbg_win     = (state == IDLE) & dbg_req & (~aligned_acc | starved);
  assign pipe_win    = (state == IDLE) & aligned_acc & ~dbg_win;

  assign pipe_stall = ~rst & aligned_acc &
                      ~((state == PIPE_BUSY) & dm_ready);

  // Arbitration FSM with registered memory, grant and completion outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      starve_cnt    <= '0;
      pipe_rdata    <= '0;
      pipe_rvalid   <= 1'b0;
      pipe_misalign <= 1'b0;
      dbg_gnt       <= 1'b0;
      dbg_rdata     <= '0;
      dbg_rvalid    <= 1'b0;
      dm_req        <= 1'b0;
      dm_we         <= 1'b0;
      dm_addr       <= '0;
      dm_wdata      <= '0;
      dm_be         <= '0;
    end else begin
      dbg_gnt       <= 1'b0;
      dbg_rvalid    <= 1'b0;
      pipe_rvalid   <= 1'b0;
      pipe_misalign <= 1'b0;
      case (state)
        IDLE: begin
          pipe_misalign <= pipe_acc & misal;
          if (dbg_win) begin
            state    <= DBG_BUSY;
            dbg_gnt  <= 1'b1;
            dm_req   <= 1'b1;
            dm_we    <= dbg_we;
            dm_addr  <= dbg_addr;
            dm_wdata <= dbg_wdata;
            dm_be    <= 4'b1111;
          end else if (pipe_win) begin
            state    <= PIPE_BUSY;
            dm_req   <= 1'b1;
            dm_we    <= mem_mem_write;
            dm_addr  <= {mem_alu_result[31:2], 2'b00};
            dm_wdata <= pipe_wdata;
            dm_be    <= mem_mem_write ? pipe_be : 4'b1111;
          end
        end
        PIPE_BUSY: begin
          if (dm_ready) begin
            state  <= IDLE;
            dm_req <= 1'b0;
            if (!dm_we) begin
              pipe_rvalid <= 1'b1;
              pipe_rdata  <= dm_rdata;
            end
          end
        end
        DBG_BUSY: begin
          if (dm_ready) begin
            state      <= IDLE;
            dm_req     <= 1'b0;
            dbg_rvalid <= 1'b1;
            if (!dm_we) begin
              dbg_rdata <= dm_rdata;
            end
          end
        end
        default: begin
          state  <= IDLE;
          dm_req <= 1'b0;
        end
      endcase
      if (dbg_win || !dbg_req) begin
        starve_cnt <= '0;
      end else if (!dbg_gnt && !starved) begin
        starve_cnt <= starve_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter_ctrl.sv
// Bench for dmem_arbiter_ctrl: directed scenarios plus random traffic
// checked every cycle against a behavioural arbitration model.
module tb_dmem_arbiter_ctrl;

  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_mem_read, mem_mem_write;
  logic [31:0] mem_alu_result, mem_rs2_val_for_store;
  logic [1:0]  mem_store_size;
  logic        pipe_stall;
  logic [31:0] pipe_rdata;
  logic        pipe_rvalid, pipe_misalign;
  logic        dbg_req, dbg_we;
  logic [31:0] dbg_addr, dbg_wdata;
  logic        dbg_gnt;
  logic [31:0] dbg_rdata;
  logic        dbg_rvalid;
  logic        dm_req, dm_we;
  logic [31:0] dm_addr, dm_wdata;
  logic [3:0]  dm_be;
  logic        dm_ready;
  logic [31:0] dm_rdata;

  dmem_arbiter_ctrl #(.STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst),
    .mem_mem_read(mem_mem_read), .mem_mem_write(mem_mem_write),
    .mem_alu_result(mem_alu_result),
    .mem_rs2_val_for_store(mem_rs2_val_for_store),
    .mem_store_size(mem_store_size),
    .pipe_stall(pipe_stall), .pipe_rdata(pipe_rdata),
    .pipe_rvalid(pipe_rvalid), .pipe_misalign(pipe_misalign),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr),
    .dbg_wdata(dbg_wdata), .dbg_gnt(dbg_gnt), .dbg_rdata(dbg_rdata),
    .dbg_rvalid(dbg_rvalid),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr),
    .dm_wdata(dm_wdata), .dm_be(dm_be),
    .dm_ready(dm_ready), .dm_rdata(dm_rdata)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Behavioural model: owner 0 = nobody, 1 = pipeline, 2 = debug
  int          m_owner;
  int          m_starve;
  logic        m_req, m_we, m_gnt, m_drv, m_prv, m_mis;
  logic [31:0] m_addr, m_wdata, m_drdata, m_prdata;
  logic [3:0]  m_be;
  logic        last_stall;

  function automatic bit m_misal();
    int sz  = int'(mem_store_size);
    int off = int'(mem_alu_result % 4);
    return (sz == 1 && off % 2 != 0) || (sz >= 2 && off != 0);
  endfunction

  function automatic logic [3:0] exp_be();
    int off = int'(mem_alu_result % 4);
    if (mem_store_size == 0) return 4'(1 << off);
    if (mem_store_size == 1) return 4'(3 << off);
    return 4'hf;
  endfunction

  function automatic logic [31:0] exp_wdata();
    logic [31:0] v = mem_rs2_val_for_store;
    if (mem_store_size == 0) return (v & 32'hff) * 32'h0101_0101;
    if (mem_store_size == 1) return (v & 32'hffff) * 32'h0001_0001;
    return v;
  endfunction

  function automatic bit m_stall();
    bit acc = mem_mem_read | mem_mem_write;
    return acc && !m_misal() && !(m_owner == 1 && dm_ready);
  endfunction

  task automatic model_reset();
    m_owner = 0; m_starve = 0;
    m_req = 0; m_we = 0; m_gnt = 0; m_drv = 0; m_prv = 0; m_mis = 0;
    m_addr = 0; m_wdata = 0; m_drdata = 0; m_prdata = 0; m_be = 0;
  endtask

  task automatic model_step();
    bit acc, mis, al, old_gnt, granted;
    acc = mem_mem_read | mem_mem_write;
    mis = m_misal();
    al = acc && !mis;
    old_gnt = m_gnt;
    granted = 0;
    m_gnt = 0; m_drv = 0; m_prv = 0; m_mis = 0;
    if (m_owner == 0) begin
      m_mis = acc && mis;
      if (dbg_req && (!al || m_starve >= LIMIT)) begin
        m_owner = 2; granted = 1; m_gnt = 1; m_req = 1;
        m_we = dbg_we; m_addr = dbg_addr;
        m_wdata = dbg_wdata; m_be = 4'hf;
      end else if (al) begin
        m_owner = 1; m_req = 1; m_we = mem_mem_write;
        m_addr = mem_alu_result - (mem_alu_result % 4);
        m_be = mem_mem_write ? exp_be() : 4'hf;
        m_wdata = exp_wdata();
      end
    end else if (dm_ready) begin
      if (m_owner == 1 && !m_we) begin
        m_prv = 1; m_prdata = dm_rdata;
      end
      if (m_owner == 2) begin
        m_drv = 1;
        if (!m_we) m_drdata = dm_rdata;
      end
      m_owner = 0; m_req = 0;
    end
    if (granted || !dbg_req) m_starve = 0;
    else if (!old_gnt && m_starve < LIMIT) m_starve++;
  endtask

  task automatic check_outs();
    check("dm_req", dm_req, m_req);
    check("dm_we", dm_we, m_we);
    check("dm_addr", dm_addr, m_addr);
    check("dm_wdata", dm_wdata, m_wdata);
    check("dm_be", dm_be, m_be);
    check("dbg_gnt", dbg_gnt, m_gnt);
    check("dbg_rvalid", dbg_rvalid, m_drv);
    check("dbg_rdata", dbg_rdata, m_drdata);
    check("pipe_rvalid", pipe_rvalid, m_prv);
    check("pipe_rdata", pipe_rdata, m_prdata);
    check("pipe_misalign", pipe_misalign, m_mis);
    check("starve_cnt", 32'(dut.starve_cnt), 32'(m_starve));
  endtask

  // Inputs are set at posedge+1; stall checked mid-cycle, state after edge
  task automatic cycle();
    #3;
    last_stall = pipe_stall;
    check("pipe_stall", pipe_stall, m_stall());
    model_step();
    @(posedge clk);
    #1;
    check_outs();
  endtask

  task automatic set_pipe(input logic rd, input logic wr,
                          input logic [31:0] a, input logic [1:0] sz,
                          input logic [31:0] d);
    mem_mem_read = rd; mem_mem_write = wr;
    mem_alu_result = a; mem_store_size = sz;
    mem_rs2_val_for_store = d;
  endtask

  task automatic no_pipe();
    set_pipe(1'b0, 1'b0, 32'h0, 2'b10, 32'h0);
  endtask

  initial begin
    int n;
    bit gnt_seen;
    rst = 1'b1;
    no_pipe();
    dbg_req = 0; dbg_we = 0; dbg_addr = 0; dbg_wdata = 0;
    dm_ready = 0; dm_rdata = 0;
    model_reset();
    @(posedge clk);
    #1;
    check_outs();
    check("rst_stall", pipe_stall, 1'b0);
    rst = 1'b0;

    // Word load with completion on the second busy cycle
    set_pipe(1, 0, 32'h100, 2'b10, 32'h0);
    cycle();
    check("ld_stall0", last_stall, 1'b1);
    check("ld_be", dm_be, 4'hf);
    check("ld_addr", dm_addr, 32'h100);
    cycle();
    check("ld_stall1", last_stall, 1'b1);
    dm_ready = 1; dm_rdata = 32'hDEADBEEF;
    cycle();
    check("ld_stall2", last_stall, 1'b0);
    check("ld_rvalid", pipe_rvalid, 1'b1);
    check("ld_rdata", pipe_rdata, 32'hDEADBEEF);
    check("ld_req_drop", dm_req, 1'b0);
    no_pipe(); dm_ready = 0;
    cycle();
    check("ld_rvalid_pulse", pipe_rvalid, 1'b0);

    // Byte store to the top lane
    set_pipe(0, 1, 32'h203, 2'b00, 32'h0000_00A5);
    cycle();
    check("sb_be", dm_be, 4'b1000);
    check("sb_wdata", dm_wdata, 32'hA5A5A5A5);
    check("sb_we", dm_we, 1'b1);
    check("sb_addr", dm_addr, 32'h200);
    dm_ready = 1;
    cycle();
    check("sb_no_rvalid", pipe_rvalid, 1'b0);
    no_pipe(); dm_ready = 0;
    cycle();

    // Misaligned half load
    set_pipe(1, 0, 32'h101, 2'b01, 32'h0);
    cycle();
    check("mis_stall", last_stall, 1'b0);
    check("mis_flag", pipe_misalign, 1'b1);
    check("mis_no_req", dm_req, 1'b0);
    no_pipe();
    cycle();
    check("mis_pulse", pipe_misalign, 1'b0);

    // Simultaneous requests: pipe first, debug right after
    set_pipe(1, 0, 32'h40, 2'b10, 32'h0);
    dbg_req = 1; dbg_we = 0; dbg_addr = 32'h80;
    cycle();
    check("sim_no_gnt", dbg_gnt, 1'b0);
    check("sim_pipe_addr", dm_addr, 32'h40);
    dm_ready = 1; dm_rdata = 32'h1111_2222;
    cycle();
    check("sim_pipe_rv", pipe_rvalid, 1'b1);
    no_pipe(); dm_ready = 0;
    cycle();
    check("sim_dbg_gnt", dbg_gnt, 1'b1);
    check("sim_dbg_addr", dm_addr, 32'h80);
    dbg_req = 0; dm_ready = 1; dm_rdata = 32'h3333_4444;
    cycle();
    check("sim_dbg_rv", dbg_rvalid, 1'b1);
    check("sim_dbg_rdata", dbg_rdata, 32'h3333_4444);
    dm_ready = 0;
    cycle();

    // Starvation: continuous pipe loads with debug held
    set_pipe(1, 0, 32'h300, 2'b10, 32'h0);
    dbg_req = 1; dbg_we = 1; dbg_addr = 32'h500; dbg_wdata = 32'hCAFE0001;
    dm_ready = 1;
    n = 0; gnt_seen = 0;
    while (!gnt_seen && n < 20) begin
      cycle();
      n++;
      if (dbg_gnt) gnt_seen = 1;
    end
    check("stv_gnt_seen", 32'(gnt_seen), 32'd1);
    check("stv_cycles", n, 5);
    check("stv_cnt_clr", 32'(dut.starve_cnt), 32'd0);
    dbg_req = 0; dm_ready = 0;
    cycle();
    check("stv_stall_dbg", last_stall, 1'b1);
    dm_ready = 1;
    cycle();
    check("stv_stall_dbg2", last_stall, 1'b1);
    check("stv_dbg_rv", dbg_rvalid, 1'b1);
    no_pipe(); dm_ready = 0;
    cycle();

    // Random traffic
    last_stall = 0;
    for (int i = 0; i < 3000; i++) begin
      if (!last_stall) begin
        if ($urandom_range(0, 9) < 3) no_pipe();
        else set_pipe(1'($urandom), 1'($urandom),
                      32'($urandom_range(0, 255)),
                      2'($urandom_range(0, 2)), $urandom);
      end
      if (dbg_req && dbg_gnt) dbg_req = 0;
      else if (dbg_req && $urandom_range(0, 19) == 0) dbg_req = 0;
      else if (!dbg_req && $urandom_range(0, 5) == 0) begin
        dbg_req = 1; dbg_we = 1'($urandom);
        dbg_addr = $urandom; dbg_wdata = $urandom;
      end
      dm_ready = ($urandom_range(0, 2) == 0);
      dm_rdata = $urandom;
      cycle();
    end

    // Drain, then reset in the middle of a pipe access
    no_pipe(); dbg_req = 0; dm_ready = 1;
    repeat (4) cycle();
    dm_ready = 0;
    set_pipe(1, 0, 32'h44, 2'b10, 32'h0);
    cycle();
    check("rstm_busy", dm_req, 1'b1);
    rst = 1'b1;
    #1;
    check("rstm_req", dm_req, 1'b0);
    check("rstm_stall", pipe_stall, 1'b0);
    model_reset();
    check_outs();
    @(posedge clk);
    #1;
    rst = 1'b0;
    no_pipe(); dm_ready = 1;
    cycle();
    check("rstm_no_rv0", pipe_rvalid, 1'b0);
    cycle();
    check("rstm_no_rv1", pipe_rvalid, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
